useq_next_addr: RTL and testbench
=================================

// Module: useq_next_addr
// PURPOSE
//  Micro-sequencer next-address unit; sits directly upstream of the micro-PC register and drives its load_incr/upc_next.
//  Decodes the next-address field of the current microinstruction against status conditions, a return-address stack
//  and a loop counter, and selects increment (upc+1), jump, conditional branch, call, return or counted loop.
// PARAMETERS
//  UPC_W      5   micro-PC / target / loop-counter width
//  DEPTH      2   return-address stack entries (1..4)
//  NCOND      4   number of condition inputs (cond_sel width = $clog2(NCOND))
// PORTS
//  clk        in   1          clock, all state on rising edge
//  reset      in   1          asynchronous, active-high reset
//  hold       in   1          stall: freeze micro-PC and all internal state
//  upc        in   UPC_W      current micro-PC (from micro-PC register)
//  op         in   3          next-address opcode (useq_op_t)
//  target     in   UPC_W      branch/call/loop target, or count value for LDCNT
//  cond_sel   in   2          selects cond_in bit
//  cond_in    in   NCOND      status conditions from datapath
//  load_incr  out  1          1 = micro-PC loads upc_next, 0 = micro-PC increments
//  upc_next   out  UPC_W      address loaded when load_incr=1
//  depth      out  3          current stack occupancy 0..DEPTH
//  err        out  1          sticky: stack overflow or underflow occurred
// BEHAVIOUR
//  - Outputs combinational from op/cond/state; state (stack, cnt, err) updates on clk edge; micro-PC takes new value 1 edge later.
//  - Reset (async, any time incl. mid-loop/mid-call): stack emptied, depth=0, cnt=0, err=0; while reset=1 load_incr=1, upc_next=0.
//  - hold=1: load_incr=1, upc_next=upc, no stack/cnt/err change regardless of op.
//  - c = cond_in[cond_sel]. "SEQ" below = load_incr=0, upc_next=0 (don't-care, drive 0).
//  - SEQ  (000): SEQ.
//  - JMP  (001): load_incr=1, upc_next=target.
//  - JC   (010): c=1 -> JMP target, else SEQ.   JNC (011): c=0 -> JMP target, else SEQ.
//  - CALL (100): depth<DEPTH -> push upc+1 (mod 2^UPC_W, 31->0), JMP target.
//               depth==DEPTH -> no push, not taken (SEQ), err<=1.
//  - RET  (101): depth>0 -> pop, load_incr=1, upc_next=popped value. depth==0 -> SEQ, err<=1.
//  - LDCNT(110): cnt<=target, SEQ.
//  - LOOP (111): cnt!=0 -> cnt<=cnt-1, JMP target; cnt==0 -> SEQ, cnt stays 0 (no wrap to all-ones).
//  - Nested loops not supported (single counter); LDCNT during a loop overwrites cnt.
//  - err sticky until reset; stack contents beyond depth are don't-care.
// STRUCTURE
//  - Package useq_pkg: localparam UPC_W; typedef enum logic [2:0] useq_op_t {SEQ,JMP,JC,JNC,CALL,RET,LDCNT,LOOP}.
//  - Sub-module useq_stack: DEPTH x UPC_W LIFO with push/pop/full/empty/depth, async active-high reset.
//  - Top: opcode decode (always_comb), cond mux, loop counter + err flop (always_ff on posedge clk, posedge reset).
// TESTING
//  - Pair with micro-PC register; reset mid-run -> depth=0, err=0, load_incr=1, upc_next=0; micro-PC =0 after release.
//  - upc=3, CALL target=20 -> upc_next=20, depth 1; later at upc=22 RET -> upc_next=4, depth 0.
//  - upc=31 CALL target=8 -> pushed 0; RET returns 0. Three CALLs with DEPTH=2 -> 3rd SEQ, err=1, depth=2.
//  - RET with depth=0 -> load_incr=0, err=1 and stays 1 over 10 cycles of SEQ.
//  - LDCNT 3 then LOOP target=5 repeated -> taken 3 times (cnt 2,1,0), 4th LOOP falls through; cnt stays 0.
//  - cond_in=4'b0100, cond_sel=2: JC 9 -> jump 9, JNC 9 -> SEQ; hold=1 with CALL -> upc_next=upc, depth unchanged.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared types for the micro-sequencer next-address logic.
package useq_pkg;

  localparam int UPC_W = 5;

  typedef enum logic [2:0] {
    SEQ   = 3'b000,
    JMP   = 3'b001,
    JC    = 3'b010,
    JNC   = 3'b011,
    CALL  = 3'b100,
    RET   = 3'b101,
    LDCNT = 3'b110,
    LOOP  = 3'b111
  } useq_op_t;

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for the micro-sequencer.
// Only the occupancy counter is reset. Entries at or above the current depth
// are don't-care, so the storage array carries no reset.
module useq_stack #(
  parameter int UPC_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [UPC_W-1:0] push_data,
  output logic [UPC_W-1:0] top,
  output logic             full,
  output logic             empty,
  output logic [2:0]       depth
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [UPC_W-1:0] mem [DEPTH];
  logic [2:0]       depth_q;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign wr_idx = depth_q[AW-1:0];
  assign rd_idx = AW'(depth_q - 3'd1);
  assign full   = (depth_q == 3'(DEPTH));
  assign empty  = (depth_q == 3'd0);
  assign top    = mem[rd_idx];
  assign depth  = depth_q;

  // Occupancy: a push on a full stack and a pop on an empty stack are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= 3'd0;
    end else if (push && !full) begin
      depth_q <= depth_q + 3'd1;
    end else if (pop && !empty) begin
      depth_q <= depth_q - 3'd1;
    end
  end

  // Storage: write the new return address into the first free slot.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/useq_next_addr.sv
// Micro-sequencer next-address unit. It decodes the next-address opcode
// against the selected condition, the return stack and the loop counter. It
// drives the load/increment control and the load address of the micro-PC.
module useq_next_addr
  import useq_pkg::*;
#(
  parameter int UPC_W = 5,
  parameter int DEPTH = 2,
  parameter int NCOND = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic [UPC_W-1:0]         upc,
  input  useq_op_t                 op,
  input  logic [UPC_W-1:0]         target,
  input  logic [$clog2(NCOND)-1:0] cond_sel,
  input  logic [NCOND-1:0]         cond_in,
  output logic                     load_incr,
  output logic [UPC_W-1:0]         upc_next,
  output logic [2:0]               depth,
  output logic                     err
);

  logic             c;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [UPC_W-1:0] top;
  logic [UPC_W-1:0] ret_addr;
  logic [UPC_W-1:0] cnt_q;
  logic             cnt_ld;
  logic             cnt_dec;
  logic             err_set;
  logic             err_q;

  assign c        = cond_in[cond_sel];
  // The return address wraps naturally at 2^UPC_W.
  assign ret_addr = upc + UPC_W'(1);
  assign err      = err_q;

  useq_stack #(
    .UPC_W (UPC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top       (top),
    .full      (full),
    .empty     (empty),
    .depth     (depth)
  );

  // Opcode decode. Reset and hold override every opcode, and no state-update strobes fire under either of them.
  always_comb begin
    load_incr = 1'b0;
    upc_next  = '0;
    push      = 1'b0;
    pop       = 1'b0;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    err_set   = 1'b0;
    if (reset) begin
      load_incr = 1'b1;
    end else if (hold) begin
      load_incr = 1'b1;
      upc_next  = upc;
    end else begin
      unique case (op)
        SEQ: ;
        JMP: begin
          load_incr = 1'b1;
          upc_next  = target;
        end
        JC, JNC: begin
          if (c == (op == JC)) begin
            load_incr = 1'b1;
            upc_next  = target;
          end
        end
        CALL: begin
          if (!full) begin
            push      = 1'b1;
            load_incr = 1'b1;
            upc_next  = target;
          end else begin
            err_set = 1'b1;
          end
        end
        RET: begin
          if (!empty) begin
            pop       = 1'b1;
            load_incr = 1'b1;
            upc_next  = top;
          end else begin
            err_set = 1'b1;
          end
        end
        LDCNT: cnt_ld = 1'b1;
        LOOP: begin
          if (cnt_q != '0) begin
            cnt_dec   = 1'b1;
            load_incr = 1'b1;
            upc_next  = target;
          end
        end
        default: ;
      endcase
    end
  end

  // Loop counter and the sticky stack-error flag. LDCNT wins over a pending decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (cnt_ld) begin
        cnt_q <= target;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - UPC_W'(1);
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_useq_next_addr.sv
// Testbench for useq_next_addr. A queue-based reference model computes the expected
// outputs for each driven cycle. A separate monitor compares them against the DUT
// on the falling edge.
module tb_useq_next_addr;
  import useq_pkg::*;

  localparam int W     = 5;
  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           hold;
  logic [W-1:0]   upc;
  useq_op_t       op;
  logic [W-1:0]   target;
  logic [1:0]     cond_sel;
  logic [3:0]     cond_in;
  logic           load_incr;
  logic [W-1:0]   upc_next;
  logic [2:0]     depth;
  logic           err;

  useq_next_addr #(.UPC_W(W), .DEPTH(DEPTH), .NCOND(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .upc       (upc),
    .op        (op),
    .target    (target),
    .cond_sel  (cond_sel),
    .cond_in   (cond_in),
    .load_incr (load_incr),
    .upc_next  (upc_next),
    .depth     (depth),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ld;
    int nxt;
    int dep;
    int er;
    int id;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Reference model state
  int   m_stk[$];
  int   m_cnt = 0;
  int   m_err = 0;

  task automatic chk(input string name, input int act, input int exp, input int id);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, id, act, exp);
    end
  endtask

  // Apply one cycle of stimulus just after the rising edge and queue its expected response.
  task automatic step(input int r, input int h, input int o, input int t,
                      input int u, input int cs, input int ci);
    exp_t e;
    int   cbit;
    @(posedge clk);
    #1;
    reset    = r[0];
    hold     = h[0];
    op       = useq_op_t'(o[2:0]);
    target   = t[W-1:0];
    upc      = u[W-1:0];
    cond_sel = cs[1:0];
    cond_in  = ci[3:0];
    e.id  = step_id++;
    e.ld  = 0;
    e.nxt = 0;
    if (r != 0) begin
      m_stk.delete();
      m_cnt = 0;
      m_err = 0;
      e.ld = 1;
      e.dep = 0;
      e.er = 0;
    end else begin
      e.dep = m_stk.size();
      e.er  = m_err;
      cbit  = (ci >> cs) & 1;
      if (h != 0) begin
        e.ld  = 1;
        e.nxt = u;
      end else begin
        case (o)
          1: begin e.ld = 1; e.nxt = t; end
          2: if (cbit == 1) begin e.ld = 1; e.nxt = t; end
          3: if (cbit == 0) begin e.ld = 1; e.nxt = t; end
          4: if (m_stk.size() < DEPTH) begin
               m_stk.push_back((u + 1) % 32);
               e.ld = 1; e.nxt = t;
             end else m_err = 1;
          5: if (m_stk.size() > 0) begin
               e.ld = 1; e.nxt = m_stk.pop_back();
             end else m_err = 1;
          6: m_cnt = t;
          7: if (m_cnt != 0) begin m_cnt--; e.ld = 1; e.nxt = t; end
          default: ;
        endcase
      end
    end
    sbq.push_back(e);
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("load_incr", int'(load_incr), e.ld, e.id);
        chk("upc_next",  int'(upc_next),  e.nxt, e.id);
        chk("depth",     int'(depth),     e.dep, e.id);
        chk("err",       int'(err),       e.er, e.id);
      end
    end
  end

  initial begin
    reset = 1'b1; hold = 1'b0; upc = '0; op = SEQ; target = '0;
    cond_sel = '0; cond_in = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 7, 4, 0, 0);
    // Call from 3 to 20, then return from 22 to 4
    step(0, 0, 4, 20, 3, 0, 0);
    step(0, 0, 0, 0, 20, 0, 0);
    step(0, 0, 0, 0, 21, 0, 0);
    step(0, 0, 5, 0, 22, 0, 0);
    step(0, 0, 0, 0, 4, 0, 0);
    // Return address wraps from 31 to 0
    step(0, 0, 4, 8, 31, 0, 0);
    step(0, 0, 5, 0, 8, 0, 0);
    // Third nested call overflows
    step(0, 0, 4, 10, 1, 0, 0);
    step(0, 0, 4, 11, 10, 0, 0);
    step(0, 0, 4, 12, 11, 0, 0);
    step(0, 0, 0, 0, 12, 0, 0);
    // Reset while the stack is full and err is set
    step(1, 0, 4, 9, 12, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Underflow, and err stays sticky
    step(0, 0, 5, 0, 2, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 3 + i, 0, 0);
    // Counted loop: LDCNT 3, then the loop is taken three times and falls through on the fourth
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 6, 3, 4, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 7, 5, 6, 0, 0);
    // Conditional branches on cond_in[2]
    step(0, 0, 2, 9, 1, 2, 4'b0100);
    step(0, 0, 3, 9, 1, 2, 4'b0100);
    step(0, 0, 2, 9, 1, 1, 4'b0100);
    step(0, 0, 3, 9, 1, 1, 4'b0100);
    // Hold freezes the stack regardless of the opcode
    step(0, 1, 4, 17, 13, 0, 0);
    step(0, 1, 5, 17, 13, 0, 0);
    step(0, 0, 0, 0, 13, 0, 0);
    // Random traffic with occasional resets and holds
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0) ? 1 : 0,
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           $urandom_range(0, 7),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 31),
           $urandom_range(0, 31),
           $urandom_range(0, 3),
           $urandom_range(0, 15));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
